// File: rtl/score_keeper.sv
// score_keeper: per-frame game-rule stage for the paddle/ball game.
//
// Watches the composite ball and paddle video against VGA blanking. Each frame is classified
// as a paddle hit, a miss (ball reached the first visible column without contact) or neither.
// Misses are counted as points, the pause/serve sequence is paced in frames, and the score
// is driven onto a 7-segment digit.
//
// Optional feature (macro SCORE_SPEEDUP_EN): counts hit frames and raises o_Speed one step
// every p_HITS_PER_STEP hits, saturating at 3. Without the macro o_Speed is tied to 0.
//
// Ports:
//   i_Clk        pixel clock
//   i_Reset      synchronous active-high reset
//   i_VReset     one-cycle pulse at frame start; frame evaluation point
//   i_HBlank     horizontal blanking level
//   i_VBlank     vertical blanking level
//   i_HBall      ball horizontal-window video
//   i_VBall      ball vertical-window video
//   i_Paddle     paddle video
//   i_Restart    level; leaves the game-over state
//   o_Serve      high for the whole serve frame (ball re-centres)
//   o_Freeze     high while paused or game over (ball motion halted)
//   o_Score      binary miss count 0..p_MAX_SCORE
//   o_Game_Over  high in the game-over state
//   o_Seg        active-low segments, bit0=A .. bit6=G, shows o_Score
//   o_Speed      speed step (optional feature)
module score_keeper #(
    parameter int unsigned p_MAX_SCORE     = 9,
    parameter int unsigned p_PAUSE_FRAMES  = 60,
    parameter int unsigned p_HITS_PER_STEP = 4
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VReset,
    input  logic       i_HBlank,
    input  logic       i_VBlank,
    input  logic       i_HBall,
    input  logic       i_VBall,
    input  logic       i_Paddle,
    input  logic       i_Restart,
    output logic       o_Serve,
    output logic       o_Freeze,
    output logic [3:0] o_Score,
    output logic       o_Game_Over,
    output logic [6:0] o_Seg,
    output logic [1:0] o_Speed
);

    typedef enum logic [1:0] {
        StPlay,
        StPause,
        StServe,
        StGameOver
    } state_t;

    localparam logic [3:0] MaxScore   = 4'(p_MAX_SCORE);
    localparam logic [7:0] PauseLoad  = 8'(p_PAUSE_FRAMES - 1);

    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] score_d;
    logic       hblank_q;
    logic       hit_q, miss_q;

    logic visible;
    logic ball_pix;
    logic first_col;

    assign visible   = ~i_HBlank & ~i_VBlank;
    assign ball_pix  = i_HBall & i_VBall & visible;
    // Rising edge of the visible region within a line.
    assign first_col = ~i_HBlank & hblank_q;

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        logic [6:0] seg;
        unique case (value)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Per-frame detection flags. Cleared on i_VReset; anything seen in that same cycle is
    // dropped so it cannot leak into the next frame.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hblank_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            hblank_q <= i_HBlank;
            if (i_VReset) begin
                hit_q  <= 1'b0;
                miss_q <= 1'b0;
            end else if (state_q == StPlay) begin
                if (ball_pix && i_Paddle) hit_q  <= 1'b1;
                if (ball_pix && first_col) miss_q <= 1'b1;
            end
        end
    end

`ifdef SCORE_SPEEDUP_EN
    localparam logic [3:0] HitsPerStep = 4'(p_HITS_PER_STEP);
    logic [3:0] hit_cnt_q, hit_cnt_d;
    logic [1:0] speed_q, speed_d;
`else
    // Parameter only matters with the speed-up feature compiled in.
    logic [3:0] unused_hits_per_step;
    assign unused_hits_per_step = 4'(p_HITS_PER_STEP);
`endif

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        score_d     = o_Score;
`ifdef SCORE_SPEEDUP_EN
        hit_cnt_d   = hit_cnt_q;
        speed_d     = speed_q;
`endif
        unique case (state_q)
            StPlay: begin
                if (i_VReset) begin
                    // A hit in the same frame as a miss cancels the point.
                    if (hit_q) begin
`ifdef SCORE_SPEEDUP_EN
                        if (hit_cnt_q + 4'd1 == HitsPerStep) begin
                            hit_cnt_d = 4'd0;
                            if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
                        end else begin
                            hit_cnt_d = hit_cnt_q + 4'd1;
                        end
`endif
                    end else if (miss_q) begin
                        if (o_Score < MaxScore) score_d = o_Score + 4'd1;
`ifdef SCORE_SPEEDUP_EN
                        speed_d = 2'd0;
`endif
                        if (score_d == MaxScore) begin
                            state_d = StGameOver;
                        end else begin
                            frame_cnt_d = PauseLoad;
                            state_d     = StPause;
                        end
                    end
                end
            end
            StPause: begin
                if (i_VReset) begin
                    if (frame_cnt_q == 8'd0) state_d = StServe;
                    else frame_cnt_d = frame_cnt_q - 8'd1;
                end
            end
            StServe: begin
                if (i_VReset) state_d = StPlay;
            end
            StGameOver: begin
                if (i_Restart) begin
                    state_d = StServe;
                    score_d = 4'd0;
`ifdef SCORE_SPEEDUP_EN
                    hit_cnt_d = 4'd0;
                    speed_d   = 2'd0;
`endif
                end
            end
            default: state_d = StServe;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= StServe;
            frame_cnt_q <= 8'd0;
            o_Score     <= 4'd0;
            o_Serve     <= 1'b1;
            o_Freeze    <= 1'b0;
            o_Game_Over <= 1'b0;
            o_Seg       <= 7'b1000000;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            o_Score     <= score_d;
            // Flags follow the registered state, so they lag the transition by one cycle.
            o_Serve     <= (state_q == StServe);
            o_Freeze    <= (state_q == StPause) || (state_q == StGameOver);
            o_Game_Over <= (state_q == StGameOver);
            o_Seg       <= seg_encode(o_Score);
        end
    end

`ifdef SCORE_SPEEDUP_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hit_cnt_q <= 4'd0;
            speed_q   <= 2'd0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
        end
    end
    assign o_Speed = speed_q;
`else
    assign o_Speed = 2'd0;
`endif

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-rule stage downstream of the ball and paddle video generators.
- Per frame, watches the composite ball and paddle video against VGA blanking and classifies the frame as a paddle hit, a miss (ball reached left screen edge without contact), or neither.
- Counts misses as points, paces the pause/serve sequence, and drives the Go Board 7-segment digit.
- Its serve output feeds the ball position logic so the ball re-centres after a miss.

Parameters:
- p_MAX_SCORE, 9: miss count (1..9) that ends the game.
- p_PAUSE_FRAMES, 60: frames the ball stays frozen after a miss (1..255).
- p_HITS_PER_STEP, 4: paddle hits per speed step (optional feature only; 1..15).

Ports:
- i_Clk  in  1  pixel clock.
- i_Reset  in  1  synchronous active-high reset.
- i_VReset  in  1  one-cycle pulse at frame start.
- i_HBlank  in  1  horizontal blanking level.
- i_VBlank  in  1  vertical blanking level.
- i_HBall  in  1  ball horizontal-window video.
- i_VBall  in  1  ball vertical-window video.
- i_Paddle  in  1  paddle video.
- i_Restart  in  1  level; leaves GAME_OVER.
- o_Serve  out  1  high for the whole SERVE frame; ball logic re-centres.
- o_Freeze  out  1  high in PAUSE and GAME_OVER; ball motion halted.
- o_Score  out  4  binary miss count 0..p_MAX_SCORE.
- o_Game_Over  out  1  high in GAME_OVER.
- o_Seg  out  7  active-low segments, bit0=A..bit6=G, shows o_Score.
- o_Speed  out  2  speed step (optional feature only).

Behaviour:
- Visible pixel: ~i_HBlank & ~i_VBlank. Ball pixel: i_HBall & i_VBall & visible.
- Hit detection: in the PLAY state, r_Hit sets when ball pixel & i_Paddle.
- Miss detection: in PLAY, r_Miss sets when the ball pixel occurs in the first visible column. The first visible column is the cycle in which i_HBlank is 0 and the registered i_HBlank from the previous cycle is 1.
- Frame evaluation: on the i_VReset cycle, r_Hit and r_Miss are evaluated, then both clear. Detections in that same cycle are discarded.
- Hit and miss in the same frame: hit wins and no point is scored.
- FSM states: PLAY, PAUSE, SERVE, GAME_OVER.
  - PLAY, miss frame evaluated: o_Score increments next cycle.
    - If the new score equals p_MAX_SCORE, go to GAME_OVER.
    - Otherwise load the frame counter with p_PAUSE_FRAMES-1 and go to PAUSE.
  - PAUSE: the counter decrements on each i_VReset. When i_VReset arrives with counter 0, go to SERVE.
  - SERVE: lasts exactly one frame, i.e. until the next i_VReset, then go to PLAY. Detections during SERVE are ignored.
  - GAME_OVER: i_Restart sampled high goes to SERVE, clears o_Score, and clears the hit count. i_Restart is ignored in other states.
- Outputs are registered from state; they change one cycle after the transition cycle.
- o_Seg is registered from o_Score: one additional cycle of latency.
- Reset (any state, including mid-pause): state=SERVE; o_Score=0; counters 0; r_Hit=r_Miss=0; o_Serve=1; o_Freeze=0; o_Game_Over=0; o_Seg=7'b1000000 (digit 0); o_Speed=0.
- o_Score never exceeds p_MAX_SCORE and never wraps.
- Segment encoding: standard 0-9. Values above 9 blank (7'h7F).

Optional Feature:
- Macro: SCORE_SPEEDUP_EN.
- Defined: each hit frame in PLAY increments a 4-bit hit counter. When it reaches p_HITS_PER_STEP, it clears and o_Speed increments, saturating at 3.
- o_Speed resets to 0 on a miss, on restart, and on i_Reset.
- Undefined: o_Speed is tied to 0 and no hit counter exists.

Test Plan:
- Reset release -> o_Serve=1 for the first frame, then PLAY; o_Score=0, o_Seg=7'b1000000.
- Ball pixel at the first visible column of line 100 with no paddle overlap -> on the next i_VReset: o_Score=1, state PAUSE, o_Freeze=1. After 60 more i_VReset pulses: o_Serve=1 for one frame, then PLAY; o_Seg=7'b1111001.
- Ball overlaps paddle and reaches the edge in the same frame -> no score change, stays PLAY.
- Nine miss frames with p_MAX_SCORE=9 -> o_Game_Over=1, o_Score=9. An extra miss frame keeps 9. i_Restart=1 -> SERVE, o_Score=0.
- i_Reset asserted mid-PAUSE (counter 30) -> next cycle state SERVE, o_Score=0, o_Freeze=0.
- With SCORE_SPEEDUP_EN defined and p_HITS_PER_STEP=4: 4 hit frames -> o_Speed=1; 16 hit frames -> o_Speed=3 (saturated); one miss -> o_Speed=0.
